// File: rtl/heap_arbiter_pkg.sv
// Shared definitions for the heap arbiter and the heap array unit it fronts.
// Holds the arbiter state encoding, the timeout error code and the heap
// action codes that both sides of the command interface agree on.
package fpga_heap_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } heap_arb_state_e;

    // Error codes returned on respError
    localparam logic [31:0] HEAP_ERR_NONE    = 32'h0000_0000;
    localparam logic [31:0] HEAP_ERR_TIMEOUT = 32'h0000_0071;

    // Heap action codes understood by the heap array unit
    localparam logic [7:0] HEAP_ACT_NOP    = 8'h00;
    localparam logic [7:0] HEAP_ACT_READ   = 8'h01;
    localparam logic [7:0] HEAP_ACT_WRITE  = 8'h02;
    localparam logic [7:0] HEAP_ACT_ALLOC  = 8'h03;
    localparam logic [7:0] HEAP_ACT_FREE   = 8'h04;
    localparam logic [7:0] HEAP_ACT_LENGTH = 8'h05;

endpackage

// File: rtl/heap_arbiter_rr_pick.sv
// Combinational round-robin picker. Searches the eligible requests
// (req & ~mask) upward starting just above the last granted engine,
// wrapping around, and returns the first hit.
module heap_rr_pick #(
    parameter int REQUESTERS = 4,
    parameter int GW         = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] i_req,
    input  logic [GW-1:0]         i_last,
    input  logic [REQUESTERS-1:0] i_mask,
    output logic                  o_valid,
    output logic [GW-1:0]         o_grant
);

    logic [REQUESTERS-1:0] w_elig;
    logic [GW-1:0]         w_idx;

    assign w_elig = i_req & ~i_mask;

    // Walk offsets from farthest to nearest so the nearest eligible engine
    // after the last grant is the final (winning) assignment.
    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        w_idx   = '0;
        for (int i = REQUESTERS; i >= 1; i--) begin
            w_idx = GW'((int'(i_last) + i) % REQUESTERS);
            if (w_elig[w_idx]) begin
                o_valid = 1'b1;
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/heap_arbiter.sv
// Heap arbiter: shares one heap array unit between REQUESTERS program
// engines. Round-robin grant, one operation in flight, one-cycle ack back
// to the winner carrying the heap result and error code.
//
// Optional build macro HEAP_ARBITER_TIMEOUT_EN: bounds the wait for
// heapDone to TIMEOUT cycles and returns HEAP_ERR_TIMEOUT when it expires.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | look for an eligible request, latch winner's command fields
// ISSUE | heapStart pulses for this single cycle
// WAIT  | wait for heapDone (or timeout), capture result and error
// RESP  | ack[g] high for one cycle, update last pointer and mask
module heap_arbiter
    import fpga_heap_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int ARRAY_W    = 2,
    parameter int INDEX_W    = 1,
    parameter int DATA_W     = 12,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [REQUESTERS-1:0]         req,
    input  logic [8*REQUESTERS-1:0]       reqAction,
    input  logic [ARRAY_W*REQUESTERS-1:0] reqArray,
    input  logic [INDEX_W*REQUESTERS-1:0] reqIndex,
    input  logic [DATA_W*REQUESTERS-1:0]  reqIn,
    output logic [REQUESTERS-1:0]         ack,
    output logic [DATA_W-1:0]             respOut,
    output logic [31:0]                   respError,
    output logic                          heapStart,
    output logic [7:0]                    heapAction,
    output logic [ARRAY_W-1:0]            heapArray,
    output logic [INDEX_W-1:0]            heapIndex,
    output logic [DATA_W-1:0]             heapIn,
    input  logic                          heapDone,
    input  logic [DATA_W-1:0]             heapOut,
    input  logic [31:0]                   heapError
);

    localparam int GW = $clog2(REQUESTERS);

    heap_arb_state_e       r_state;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_last;
    logic [REQUESTERS-1:0] r_mask;
    logic [REQUESTERS-1:0] r_ack;
    logic                  r_heap_start;
    logic [7:0]            r_heap_action;
    logic [ARRAY_W-1:0]    r_heap_array;
    logic [INDEX_W-1:0]    r_heap_index;
    logic [DATA_W-1:0]     r_heap_in;
    logic [DATA_W-1:0]     r_resp_out;
    logic [31:0]           r_resp_err;

`ifdef HEAP_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]      r_wait_cnt;
`endif

    logic                  w_pick_valid;
    logic [GW-1:0]         w_pick_grant;
    logic [REQUESTERS-1:0] w_grant_1h;
    logic [7:0]            w_sel_action;
    logic [ARRAY_W-1:0]    w_sel_array;
    logic [INDEX_W-1:0]    w_sel_index;
    logic [DATA_W-1:0]     w_sel_in;

    heap_rr_pick #(
        .REQUESTERS (REQUESTERS),
        .GW         (GW)
    ) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .i_mask  (r_mask),
        .o_valid (w_pick_valid),
        .o_grant (w_pick_grant)
    );

    assign w_grant_1h = {{(REQUESTERS-1){1'b0}}, 1'b1} << r_grant;

    // Select the picked engine's command fields out of the packed buses
    always_comb begin
        w_sel_action = '0;
        w_sel_array  = '0;
        w_sel_index  = '0;
        w_sel_in     = '0;
        for (int g = 0; g < REQUESTERS; g++) begin
            if (w_pick_grant == GW'(g)) begin
                w_sel_action = reqAction[8*g +: 8];
                w_sel_array  = reqArray[ARRAY_W*g +: ARRAY_W];
                w_sel_index  = reqIndex[INDEX_W*g +: INDEX_W];
                w_sel_in     = reqIn[DATA_W*g +: DATA_W];
            end
        end
    end

    // Arbiter FSM with registered heap command and response outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_last        <= GW'(REQUESTERS - 1);
            r_mask        <= '0;
            r_ack         <= '0;
            r_heap_start  <= 1'b0;
            r_heap_action <= '0;
            r_heap_array  <= '0;
            r_heap_index  <= '0;
            r_heap_in     <= '0;
            r_resp_out    <= '0;
            r_resp_err    <= '0;
`ifdef HEAP_ARBITER_TIMEOUT_EN
            r_wait_cnt    <= '0;
`endif
        end else begin
            r_heap_start <= 1'b0;
            r_ack        <= '0;
            case (r_state)
                IDLE: begin
                    // mask only ever shields the one IDLE cycle after RESP
                    r_mask <= '0;
                    if (w_pick_valid) begin
                        r_grant       <= w_pick_grant;
                        r_heap_action <= w_sel_action;
                        r_heap_array  <= w_sel_array;
                        r_heap_index  <= w_sel_index;
                        r_heap_in     <= w_sel_in;
                        r_heap_start  <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // heapDone here belongs to nobody and is dropped
`ifdef HEAP_ARBITER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (heapDone) begin
                        r_resp_out <= heapOut;
                        r_resp_err <= heapError;
                        r_ack      <= w_grant_1h;
                        r_state    <= RESP;
                    end
`ifdef HEAP_ARBITER_TIMEOUT_EN
                    else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_resp_out <= '0;
                        r_resp_err <= HEAP_ERR_TIMEOUT;
                        r_ack      <= w_grant_1h;
                        r_state    <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    r_last  <= r_grant;
                    r_mask  <= w_grant_1h;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign respOut    = r_resp_out;
    assign respError  = r_resp_err;
    assign heapStart  = r_heap_start;
    assign heapAction = r_heap_action;
    assign heapArray  = r_heap_array;
    assign heapIndex  = r_heap_index;
    assign heapIn     = r_heap_in;

endmodule

// File: tb/tb_heap_arbiter.sv
// Directed testbench for heap_arbiter (REQUESTERS=4, ARRAY_W=2, INDEX_W=1,
// DATA_W=12). Built with HEAP_ARBITER_TIMEOUT_EN it runs the timeout
// scenario with TIMEOUT=10, otherwise it checks that WAIT never gives up.
module tb_heap_arbiter;

    localparam int R  = 4;
    localparam int AW = 2;
    localparam int IW = 1;
    localparam int DW = 12;
`ifdef HEAP_ARBITER_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [R-1:0]    req = '0;
    logic [8*R-1:0]  reqAction = '0;
    logic [AW*R-1:0] reqArray = '0;
    logic [IW*R-1:0] reqIndex = '0;
    logic [DW*R-1:0] reqIn = '0;
    logic [R-1:0]    ack;
    logic [DW-1:0]   respOut;
    logic [31:0]     respError;
    logic            heapStart;
    logic [7:0]      heapAction;
    logic [AW-1:0]   heapArray;
    logic [IW-1:0]   heapIndex;
    logic [DW-1:0]   heapIn;
    logic            heapDone = 1'b0;
    logic [DW-1:0]   heapOut = '0;
    logic [31:0]     heapError = '0;

    int n_vec = 0;
    int n_err = 0;
    int starts_seen = 0;

    heap_arbiter #(
        .REQUESTERS (R),
        .ARRAY_W    (AW),
        .INDEX_W    (IW),
        .DATA_W     (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .reqAction  (reqAction),
        .reqArray   (reqArray),
        .reqIndex   (reqIndex),
        .reqIn      (reqIn),
        .ack        (ack),
        .respOut    (respOut),
        .respError  (respError),
        .heapStart  (heapStart),
        .heapAction (heapAction),
        .heapArray  (heapArray),
        .heapIndex  (heapIndex),
        .heapIn     (heapIn),
        .heapDone   (heapDone),
        .heapOut    (heapOut),
        .heapError  (heapError)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, want finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req       = '0;
        heapDone  = 1'b0;
        reset     = 1'b0;
        tick();
        tick();
        reset     = 1'b1;
        tick();
    endtask

    task automatic set_fields(input int g, input logic [7:0] act, input logic [AW-1:0] arr,
                              input logic [IW-1:0] idx, input logic [DW-1:0] din);
        reqAction[8*g +: 8]   = act;
        reqArray[AW*g +: AW]  = arr;
        reqIndex[IW*g +: IW]  = idx;
        reqIn[DW*g +: DW]     = din;
    endtask

    // leaves the bench in the heapStart cycle when ok=1
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (heapStart === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // called in the heapStart cycle; heapDone k cycles later; returns in the ack cycle
    task automatic pulse_done(input int k, input logic [DW-1:0] dout, input logic [31:0] derr);
        repeat (k) begin
            tick();
            if (heapStart === 1'b1) starts_seen++;
        end
        heapOut   = dout;
        heapError = derr;
        heapDone  = 1'b1;
        tick();
        if (heapStart === 1'b1) starts_seen++;
        heapDone  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_vec++; if (heapStart !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", heapStart); end
        n_vec++; if ({heapAction, heapArray, heapIndex, heapIn} !== 23'h0) begin n_err++;
            $display("FAIL reset_heap_regs: got %h want 0", {heapAction, heapArray, heapIndex, heapIn}); end
        n_vec++; if (respOut !== 12'h000) begin n_err++; $display("FAIL reset_respOut: got %h want 000", respOut); end
        n_vec++; if (respError !== 32'h0) begin n_err++; $display("FAIL reset_respError: got %h want 0", respError); end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int hs_cyc, ack_cyc, nstart, nack;
        logic [7:0] act_v; logic [AW-1:0] arr_v; logic [IW-1:0] idx_v; logic [DW-1:0] in_v;
        logic [R-1:0] ack_v; logic [DW-1:0] out_v; logic [31:0] err_v;
        do_reset();
        for (int g = 0; g < R; g++) set_fields(g, 8'hE0 + 8'(g), 2'(3 - g), 1'b1, 12'hF00 + 12'(g));
        set_fields(2, 8'h03, 2'd1, 1'b0, 12'h5A5);
        hs_cyc = -1; ack_cyc = -1; nstart = 0; nack = 0;
        act_v = '0; arr_v = '0; idx_v = '0; in_v = '0; ack_v = '0; out_v = '0; err_v = '0;
        heapOut = 12'h123;
        heapError = 32'h0;
        req = 4'b0100;
        for (int c = 1; c <= 16; c++) begin
            tick();
            heapDone = (c == 4);
            if (heapStart === 1'b1) begin
                nstart++;
                if (hs_cyc < 0) begin
                    hs_cyc = c; act_v = heapAction; arr_v = heapArray; idx_v = heapIndex; in_v = heapIn;
                end
            end
            if (ack !== 4'b0000) begin
                nack++;
                if (ack_cyc < 0) begin
                    ack_cyc = c; ack_v = ack; out_v = respOut; err_v = respError;
                    req = '0;
                end
            end
        end
        n_vec++; if (hs_cyc != 1) begin n_err++; $display("FAIL single_start_cycle: got %0d want 1", hs_cyc); end
        n_vec++; if (nstart != 1) begin n_err++; $display("FAIL single_start_count: got %0d want 1", nstart); end
        n_vec++; if (act_v !== 8'h03) begin n_err++; $display("FAIL single_action: got %h want 03", act_v); end
        n_vec++; if (arr_v !== 2'd1) begin n_err++; $display("FAIL single_array: got %h want 1", arr_v); end
        n_vec++; if (idx_v !== 1'b0) begin n_err++; $display("FAIL single_index: got %h want 0", idx_v); end
        n_vec++; if (in_v !== 12'h5A5) begin n_err++; $display("FAIL single_in: got %h want 5a5", in_v); end
        n_vec++; if (ack_cyc != 5) begin n_err++; $display("FAIL single_ack_cycle: got %0d want 5", ack_cyc); end
        n_vec++; if (nack != 1) begin n_err++; $display("FAIL single_ack_width: got %0d want 1", nack); end
        n_vec++; if (ack_v !== 4'b0100) begin n_err++; $display("FAIL single_ack: got %b want 0100", ack_v); end
        n_vec++; if (out_v !== 12'h123) begin n_err++; $display("FAIL single_respOut: got %h want 123", out_v); end
        n_vec++; if (err_v !== 32'h0) begin n_err++; $display("FAIL single_respError: got %h want 0", err_v); end
        n_vec++; if (heapIn !== 12'h5A5) begin n_err++; $display("FAIL single_heapIn_hold: got %h want 5a5", heapIn); end
    endtask

    task automatic test_fairness();
        bit ok;
        int eng;
        logic [R-1:0] exp_ack;
        do_reset();
        for (int g = 0; g < R; g++) set_fields(g, 8'h10 + 8'(g), 2'(g), 1'(g), 12'h100 + 12'(g));
        req = 4'b1111;
        for (int op = 0; op < 8; op++) begin
            wait_start(ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL fair_start_%0d: got none want heapStart", op); end
            if (ok) begin
                eng = int'(heapAction) - 16;
                n_vec++; if (eng != op % R) begin n_err++; $display("FAIL fair_grant_%0d: got %0d want %0d", op, eng, op % R); end
                starts_seen = 0;
                pulse_done(2, 12'h200 + 12'(op), 32'h0);
                exp_ack = 4'b0001 << (op % R);
                n_vec++; if (starts_seen != 0) begin n_err++; $display("FAIL fair_single_flight_%0d: got %0d extra starts want 0", op, starts_seen); end
                n_vec++; if (ack !== exp_ack) begin n_err++; $display("FAIL fair_ack_%0d: got %b want %b", op, ack, exp_ack); end
                n_vec++; if (respOut !== 12'h200 + 12'(op)) begin n_err++; $display("FAIL fair_respOut_%0d: got %h want %h", op, respOut, 12'h200 + 12'(op)); end
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_hold_extra();
        bit ok;
        do_reset();
        set_fields(1, 8'h21, 2'd2, 1'b1, 12'h3C3);
        req = 4'b0010;
        wait_start(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL hold_start: got none want heapStart"); end
        pulse_done(1, 12'h444, 32'h0);
        n_vec++; if (ack !== 4'b0010) begin n_err++; $display("FAIL hold_ack: got %b want 0010", ack); end
        tick();
        tick();
        req = '0;
        n_vec++; if (heapStart !== 1'b0) begin n_err++; $display("FAIL hold_masked: got %b want 0", heapStart); end
        starts_seen = 0;
        repeat (5) begin
            tick();
            if (heapStart === 1'b1) starts_seen++;
        end
        n_vec++; if (starts_seen != 0) begin n_err++; $display("FAIL hold_no_regrant: got %0d starts want 0", starts_seen); end
        req = 4'b0010;
        wait_start(ok);
        pulse_done(1, 12'h555, 32'h0);
        n_vec++; if (respOut !== 12'h555) begin n_err++; $display("FAIL hold2_respOut: got %h want 555", respOut); end
        tick();
        tick();
        n_vec++; if (heapStart !== 1'b0) begin n_err++; $display("FAIL hold2_masked: got %b want 0", heapStart); end
        tick();
        n_vec++; if (heapStart !== 1'b1) begin n_err++; $display("FAIL hold2_regrant: got %b want 1", heapStart); end
        pulse_done(1, 12'h666, 32'h0);
        req = '0;
        n_vec++; if (ack !== 4'b0010) begin n_err++; $display("FAIL hold2_ack: got %b want 0010", ack); end
        n_vec++; if (respOut !== 12'h666) begin n_err++; $display("FAIL hold2_respOut2: got %h want 666", respOut); end
        tick();
    endtask

    task automatic test_error();
        bit ok;
        do_reset();
        set_fields(3, 8'h05, 2'd3, 1'b1, 12'h0F0);
        set_fields(0, 8'h01, 2'd0, 1'b0, 12'h00F);
        req = 4'b1000;
        wait_start(ok);
        pulse_done(2, 12'hABC, 32'h0000_0005);
        req = '0;
        n_vec++; if (ack !== 4'b1000) begin n_err++; $display("FAIL err_ack: got %b want 1000", ack); end
        n_vec++; if (respError !== 32'h5) begin n_err++; $display("FAIL err_respError: got %h want 5", respError); end
        n_vec++; if (respOut !== 12'hABC) begin n_err++; $display("FAIL err_respOut: got %h want abc", respOut); end
        tick();
        req = 4'b0001;
        wait_start(ok);
        pulse_done(1, 12'h001, 32'h0);
        req = '0;
        n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL err_next_ack: got %b want 0001", ack); end
        n_vec++; if (respError !== 32'h0) begin n_err++; $display("FAIL err_next_respError: got %h want 0", respError); end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int nack;
        do_reset();
        set_fields(0, 8'h0A, 2'd0, 1'b0, 12'h0A0);
        set_fields(2, 8'h0C, 2'd2, 1'b0, 12'h0C0);
        set_fields(3, 8'h0D, 2'd3, 1'b1, 12'h0D0);
        req = 4'b0100;
        wait_start(ok);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_vec++; if (heapAction !== 8'h00) begin n_err++; $display("FAIL rmid_action: got %h want 00", heapAction); end
        n_vec++; if (heapIn !== 12'h000) begin n_err++; $display("FAIL rmid_in: got %h want 000", heapIn); end
        tick();
        reset = 1'b1;
        req = '0;
        tick();
        heapOut = 12'h7FF;
        heapError = 32'h9;
        heapDone = 1'b1;
        tick();
        heapDone = 1'b0;
        nack = 0;
        for (int i = 0; i < 4; i++) begin
            if (ack !== 4'b0000) nack++;
            tick();
        end
        n_vec++; if (nack != 0) begin n_err++; $display("FAIL rmid_no_ack: got %0d acks want 0", nack); end
        n_vec++; if (respOut !== 12'h000) begin n_err++; $display("FAIL rmid_respOut: got %h want 000", respOut); end
        n_vec++; if (respError !== 32'h0) begin n_err++; $display("FAIL rmid_respError: got %h want 0", respError); end
        req = 4'b1101;
        wait_start(ok);
        n_vec++; if (heapAction !== 8'h0A) begin n_err++; $display("FAIL rmid_prio: got %h want 0a", heapAction); end
        pulse_done(1, 12'h010, 32'h0);
        req = '0;
        n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL rmid_ack: got %b want 0001", ack); end
        tick();
    endtask

`ifdef HEAP_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n, nack;
        do_reset();
        set_fields(1, 8'h02, 2'd1, 1'b1, 12'h111);
        heapOut = 12'hFFF;
        heapError = 32'h3;
        req = 4'b0010;
        wait_start(ok);
        tick();
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ack !== 4'b0000) begin
                n = i;
                break;
            end
        end
        n_vec++; if (n != 10) begin n_err++; $display("FAIL to_latency: got %0d want 10", n); end
        n_vec++; if (ack !== 4'b0010) begin n_err++; $display("FAIL to_ack: got %b want 0010", ack); end
        n_vec++; if (respError !== 32'h71) begin n_err++; $display("FAIL to_respError: got %h want 71", respError); end
        n_vec++; if (respOut !== 12'h000) begin n_err++; $display("FAIL to_respOut: got %h want 000", respOut); end
        req = '0;
        tick();
        heapDone = 1'b1;
        tick();
        heapDone = 1'b0;
        nack = 0;
        for (int i = 0; i < 5; i++) begin
            if (ack !== 4'b0000) nack++;
            tick();
        end
        n_vec++; if (nack != 0) begin n_err++; $display("FAIL to_late_done: got %0d acks want 0", nack); end
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        int nack;
        do_reset();
        set_fields(1, 8'h02, 2'd1, 1'b1, 12'h111);
        req = 4'b0010;
        wait_start(ok);
        nack = 0;
        repeat (300) begin
            tick();
            if (ack !== 4'b0000) nack++;
        end
        n_vec++; if (nack != 0) begin n_err++; $display("FAIL nto_no_ack: got %0d acks want 0", nack); end
        heapOut = 12'h9A9;
        heapError = 32'h0;
        heapDone = 1'b1;
        tick();
        heapDone = 1'b0;
        req = '0;
        n_vec++; if (ack !== 4'b0010) begin n_err++; $display("FAIL nto_ack: got %b want 0010", ack); end
        n_vec++; if (respOut !== 12'h9A9) begin n_err++; $display("FAIL nto_respOut: got %h want 9a9", respOut); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_hold_extra();
        test_error();
        test_reset_mid();
`ifdef HEAP_ARBITER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
